// File: rtl/lsu_mem_req.sv
// Load/store initiator: takes one pipeline request at a time, drives the memory
// responder with registered strobes, and returns an aligned, extended response.
module lsu_mem_req #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned WDT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_load,
    input  logic             req_is_store,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    input  logic [WDT_W-1:0] req_wdt,
    input  logic             req_signed,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_err,
    output logic [XLEN-1:0]  mem_raddr,
    output logic [XLEN-1:0]  mem_waddr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [WDT_W-1:0] wdt_op,
    input  logic [XLEN-1:0]  mem_rdata
);

    localparam logic [WDT_W-1:0] WDT8  = WDT_W'(4'b0001);
    localparam logic [WDT_W-1:0] WDT16 = WDT_W'(4'b0010);
    localparam logic [WDT_W-1:0] WDT32 = WDT_W'(4'b0100);
    localparam logic [WDT_W-1:0] WDT64 = WDT_W'(4'b1000);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_DATA  = 3'd2,
        WR       = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              signed_q;
    logic [2:0]        align_mask_c;
    logic              bad_req_c;
    logic [XLEN-1:0]   ext_rdata_c;

    // Request legality: one-hot width, exactly one of load/store, natural alignment
    always_comb begin
        align_mask_c = 3'd0;
        case (req_wdt)
            WDT16:   align_mask_c = 3'd1;
            WDT32:   align_mask_c = 3'd3;
            WDT64:   align_mask_c = 3'd7;
            default: align_mask_c = 3'd0;
        endcase
        bad_req_c = !$onehot(req_wdt)
                  || (req_is_load == req_is_store)
                  || (|(req_addr[2:0] & align_mask_c));
    end

    // Sign extension of the zero-extended read data, keyed off the held width
    always_comb begin
        ext_rdata_c = mem_rdata;
        if (signed_q) begin
            case (wdt_op)
                WDT8:    ext_rdata_c = {{(XLEN-8){mem_rdata[7]}},   mem_rdata[7:0]};
                WDT16:   ext_rdata_c = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
                WDT32:   ext_rdata_c = {{(XLEN-32){mem_rdata[31]}}, mem_rdata[31:0]};
                default: ext_rdata_c = mem_rdata;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad_req_c)        state_d = RESP;
                    else if (req_is_load) state_d = RD_ISSUE;
                    else                  state_d = WR;
                end
            end
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA:  state_d = RESP;
            WR:       state_d = RESP;
            RESP:     if (resp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Registered outputs follow the next state so strobes line up with their states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            wdt_op     <= '0;
            signed_q   <= 1'b0;
        end else begin
            req_ready  <= (state_d == IDLE);
            resp_valid <= (state_d == RESP);
            mem_ren    <= (state_d == RD_ISSUE);
            mem_wen    <= (state_d == WR);
            if (state_q == IDLE && req_valid) begin
                mem_raddr <= req_addr;
                mem_waddr <= req_addr;
                mem_wdata <= req_wdata;
                wdt_op    <= req_wdt;
                signed_q  <= req_signed;
                if (bad_req_c) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
            if (state_q == RD_DATA) begin
                resp_rdata <= ext_rdata_c;
                resp_err   <= 1'b0;
            end
            if (state_q == WR) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed, table-driven bench for lsu_mem_req with a memory stub that presents
// read data only in the cycle the responder would.
module tb_lsu_mem_req;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned WDT_W = 4;
    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_CAFE_F00D;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_is_load, req_is_store, req_signed;
    logic [XLEN-1:0]  req_addr, req_wdata;
    logic [WDT_W-1:0] req_wdt;
    logic             resp_valid, resp_ready, resp_err;
    logic [XLEN-1:0]  resp_rdata, mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic             mem_ren, mem_wen;
    logic [WDT_W-1:0] wdt_op;

    int tests = 0;
    int fails = 0;

    lsu_mem_req #(.XLEN(XLEN), .WDT_W(WDT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wdt(req_wdt),
        .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  wdt;
        logic        sgn;
        logic [63:0] rd;
        logic        err;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(string n, logic ld, logic st, logic [63:0] a,
                                logic [63:0] wd, logic [3:0] w, logic s,
                                logic [63:0] rd, logic e, logic [63:0] x, int lat);
        vec_t v;
        v.name = n; v.ld = ld; v.st = st; v.addr = a; v.wdata = wd; v.wdt = w;
        v.sgn = s; v.rd = rd; v.err = e; v.exp = x; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request to completion, optionally holding off the response
    task automatic run_req(input vec_t v, input int hold);
        int lat, ren_n, wen_n, waited;
        logic [63:0] held_rdata;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        check({v.name, " req_ready before"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_is_load = v.ld; req_is_store = v.st;
        req_addr = v.addr; req_wdata = v.wdata; req_wdt = v.wdt; req_signed = v.sgn;
        mem_rdata = GARBAGE;
        tick();
        req_valid = 1'b0; req_addr = GARBAGE; req_wdata = GARBAGE;
        req_wdt = 4'b0001; req_signed = ~v.sgn;
        lat = 0; ren_n = 0; wen_n = 0;
        for (int n = 1; n <= 20; n++) begin
            mem_rdata = (n == 2) ? v.rd : GARBAGE;
            if (mem_ren && mem_wen) check({v.name, " ren&wen"}, 64'd1, 64'd0);
            if (mem_ren) begin
                ren_n++;
                check({v.name, " raddr"}, mem_raddr, v.addr);
                check({v.name, " rd wdt_op"}, 64'(wdt_op), 64'(v.wdt));
            end
            if (mem_wen) begin
                wen_n++;
                check({v.name, " waddr"}, mem_waddr, v.addr);
                check({v.name, " wdata"}, mem_wdata, v.wdata);
                check({v.name, " wr wdt_op"}, 64'(wdt_op), 64'(v.wdt));
            end
            if (resp_valid) begin
                lat = n;
                break;
            end
            if (req_ready) check({v.name, " req_ready busy"}, 64'd1, 64'd0);
            tick();
        end
        check({v.name, " latency"}, 64'(lat), 64'(v.lat));
        check({v.name, " err"}, 64'(resp_err), 64'(v.err));
        check({v.name, " rdata"}, resp_rdata, v.exp);
        check({v.name, " ren pulses"}, 64'(ren_n), (v.lat == 3) ? 64'd1 : 64'd0);
        check({v.name, " wen pulses"}, 64'(wen_n), (v.lat == 2) ? 64'd1 : 64'd0);
        held_rdata = resp_rdata;
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
            req_addr = 64'h8000_0040; req_wdt = 4'b1000;
            tick();
            check({v.name, " bp valid"}, 64'(resp_valid), 64'd1);
            check({v.name, " bp rdata"}, resp_rdata, held_rdata);
            check({v.name, " bp req_ready"}, 64'(req_ready), 64'd0);
            check({v.name, " bp mem"}, 64'({mem_ren, mem_wen}), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({v.name, " valid drop"}, 64'(resp_valid), 64'd0);
        check({v.name, " back idle"}, 64'(req_ready), 64'd1);
        check({v.name, " idle mem"}, 64'({mem_ren, mem_wen}), 64'd0);
    endtask

    initial begin
        vecs[0]  = mk("lb_s",    1, 0, 64'h8000_0003, 0, 4'b0001, 1, 64'h80, 0, 64'hFFFF_FFFF_FFFF_FF80, 3);
        vecs[1]  = mk("lhu",     1, 0, 64'h8000_0006, 0, 4'b0010, 0, 64'h8001, 0, 64'h8001, 3);
        vecs[2]  = mk("sd",      0, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 4'b1000, 0, 0, 0, 0, 2);
        vecs[3]  = mk("lh_s",    1, 0, 64'h8000_0002, 0, 4'b0010, 1, 64'h8001, 0, 64'hFFFF_FFFF_FFFF_8001, 3);
        vecs[4]  = mk("lw_mis",  1, 0, 64'h8000_0002, 0, 4'b0100, 0, 0, 1, 0, 1);
        vecs[5]  = mk("lw_s",    1, 0, 64'h8000_0004, 0, 4'b0100, 1, 64'h8000_0000, 0, 64'hFFFF_FFFF_8000_0000, 3);
        vecs[6]  = mk("lw_pos",  1, 0, 64'h8000_0008, 0, 4'b0100, 1, 64'h7FFF_FFFF, 0, 64'h7FFF_FFFF, 3);
        vecs[7]  = mk("ld_s",    1, 0, 64'h8000_0018, 0, 4'b1000, 1, 64'h8000_0000_0000_0001, 0, 64'h8000_0000_0000_0001, 3);
        vecs[8]  = mk("ld_mis",  1, 0, 64'h8000_0004, 0, 4'b1000, 0, 0, 1, 0, 1);
        vecs[9]  = mk("lbu",     1, 0, 64'h8000_0001, 0, 4'b0001, 0, 64'hFF, 0, 64'hFF, 3);
        vecs[10] = mk("sb",      0, 1, 64'h8000_0005, 64'hAB, 4'b0001, 0, 0, 0, 0, 2);
        vecs[11] = mk("sh_mis",  0, 1, 64'h8000_0001, 64'h1234, 4'b0010, 0, 0, 1, 0, 1);
        vecs[12] = mk("ld_st",   1, 1, 64'h8000_0000, 0, 4'b0001, 0, 0, 1, 0, 1);
        vecs[13] = mk("neither", 0, 0, 64'h8000_0000, 0, 4'b0001, 0, 0, 1, 0, 1);
        vecs[14] = mk("wdt_2hot",1, 0, 64'h8000_0000, 0, 4'b0011, 0, 0, 1, 0, 1);
        vecs[15] = mk("sw",      0, 1, 64'h8000_0020, 64'hFFFF_FFFF_8765_4321, 4'b0100, 0, 0, 0, 0, 2);

        rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_addr = '0; req_wdata = '0; req_wdt = '0; req_signed = 1'b0;
        resp_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset outputs", 64'({resp_valid, resp_err, mem_ren, mem_wen, wdt_op}), 64'd0);
        check("reset rdata", resp_rdata | mem_raddr | mem_waddr | mem_wdata, 64'd0);
        #2 rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) run_req(vecs[i], 0);

        // Response held off for five cycles with a stray request on the inputs
        run_req(vecs[0], 5);
        // Error right after a load must clear resp_rdata
        run_req(vecs[4], 0);

        // Reset in the middle of the write cycle
        req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
        req_addr = 64'h8000_0030; req_wdata = 64'h55; req_wdt = 4'b0001;
        tick();
        req_valid = 1'b0;
        check("wr before rst", 64'(mem_wen), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst wen drop", 64'(mem_wen), 64'd0);
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd0);
        tick();
        #2 rst = 1'b0;
        tick();
        check("post rst ready", 64'(req_ready), 64'd1);
        check("post rst mem", 64'({mem_ren, mem_wen, resp_valid}), 64'd0);
        run_req(vecs[1], 0);
        run_req(vecs[2], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
